axi_stream_to_mem: RTL and testbench
====================================

Name: axi_stream_to_mem

Overview:
- DMA-style write engine: accepts an AXI4-Stream packet and stores it to memory through an AXI3 write-only master port.
- APB slave CSR block configures the engine, reports status and drives a level interrupt.
- Sits between a streaming producer (e.g. FFT output) and the system AXI memory.
- Single clock domain: stream, AXI and APB all run on ACLK.

Parameters:
- AXI_MST_ID, 1, constant driven on M_MID.
- AXI_WIDTH_CID, 2, M_MID width.
- AXI_WIDTH_ID, 4, AWID/WID/BID width.
- AXI_WIDTH_AD, 32, AXI address width.
- AXI_WIDTH_DA, 64, AXI data width; AXIS_WIDTH_DATA must equal it.
- AXIS_WIDTH_DATA, 64, stream data width.
- AXIS_WIDTH_DS, AXIS_WIDTH_DATA/8, TSTRB width.
- FIFO_DEPTH, 16, beat buffer depth (power of 2, ≥16).

Ports:
- ARESETn in 1: asynchronous active-low reset for the whole block.
- ACLK in 1: the single clock.
- M_MID out CID: equals AXI_MST_ID.
- M_AWID/M_WID out ID: constant 0.
- M_BID in ID: ignored.
- M_AWADDR out AD; M_AWLEN out 4; M_AWSIZE out 3 (log2 bytes/beat); M_AWBURST out 2 (INCR=01); M_AWLOCK out 2 (00).
- M_AWVALID out 1; M_AWREADY in 1.
- M_WDATA out DA; M_WSTRB out DA/8; M_WLAST/M_WVALID out 1; M_WREADY in 1.
- M_BRESP in 2; M_BVALID in 1; M_BREADY out 1.
- AXIS_TREADY out 1; AXIS_TVALID in 1; AXIS_TDATA in DATA; AXIS_TSTRB in DS; AXIS_TLAST in 1; AXIS_TSTART in 1: first beat of packet.
- PSEL/PENABLE/PWRITE in 1; PADDR in 32; PWDATA in 32; PSTRB in 4; PPROT in 3 (ignored).
- PRDATA out 32; PREADY out 1 (always 1); PSLVERR out 1 (always 0).
- IRQ out 1.
- No AXI read channel; the integrator ties the memory read side idle.

Behaviour:
- Reset: all outputs 0 except PREADY=1. CSRs at 0, FIFO empty, FSM IDLE. Asserting reset mid-transfer aborts immediately; no completion of the outstanding burst.
- CSR map (offset[4:0]; write honours PSTRB; write/read in the ACCESS phase):
  - 0x00 CTRL: bit0 GO (self-clears when DONE sets); bit1 IE.
  - 0x04 STATUS: bit0 BUSY (RO); bit1 DONE (W1C); bit2 ERR (W1C).
  - 0x08 START: byte address, low log2(DA/8) bits forced 0.
  - 0x0C END: exclusive byte limit.
  - 0x10 COUNT (RO): bytes written since GO.
  - 0x14 CHUNK: max beats per burst, 1..16; 0 is treated as 16.
- Stream intake:
  - AXIS_TREADY = BUSY & FIFO not full & !last_seen.
  - After GO, beats are discarded (TREADY=1) until a beat with TSTART=1; that beat and later ones are pushed as {data, strb, last}.
- Burst issue (one outstanding transaction):
  - FSM IDLE -> WAIT -> AW -> W -> B -> WAIT or DONE.
  - In WAIT, issue when FIFO count ≥ len, or when a last-flagged beat is in the FIFO.
  - len = min(CHUNK, FIFO count, (END-addr)/bytes, beats to next 4 KB boundary).
  - AWLEN = len-1; AWVALID held until AWREADY.
  - W: pop a FIFO beat on WVALID&WREADY. WLAST on beat len. WSTRB = TSTRB.
  - B: BREADY=1 in B state. On BVALID, addr += len*bytes and COUNT += len*bytes.
- Completion: DONE when a burst containing TLAST completes, or when addr reaches END.
  - If END is reached before TLAST, remaining stream beats stay stalled (TREADY=0) until the next GO.
- Error: BRESP≠00 sets ERR and DONE and stops the engine. The FIFO is flushed on the next GO.
- GO while BUSY is ignored. GO sets addr=START, COUNT=0, clears last_seen.
- IRQ = IE & (DONE | ERR), registered (1-cycle latency after the status change).

Decomposition:
- Shared package: CSR offsets, AXI burst/resp encodings, FSM state enum.
- One sub-module: axi_stream_to_mem_fifo (synchronous FIFO with count output).

Test Plan:
- Reset: read all CSRs -> 0; TREADY=0; IRQ=0.
- START=0, END=0x400, CHUNK=8, IE=1, GO; 16-beat packet with TLAST on beat 16 -> two AW (0x000 and 0x040, AWLEN=7); COUNT=0x80; DONE=1; IRQ=1. Write 0x2 to STATUS -> IRQ=0.
- 5-beat packet, CHUNK=8 -> one AW with AWLEN=4; memory holds the data at 0x00..0x27.
- START=0x100, END=0x120, 8-beat stream -> one 4-beat burst; DONE=1; TREADY=0 with 4 beats unsent.
- START=0xFE0, CHUNK=16 -> first burst AWLEN=3 (0xFE0) and the next burst starts at 0x1000; no burst crosses 4 KB.
- Slave returns BRESP=10 -> ERR=1, DONE=1, IRQ=1, no further AW. Random WREADY/AWREADY stalls leave the data intact.

Source files
------------

// File: rtl/axi_stream_to_mem_pkg.sv
// axi_stream_to_mem_pkg: CSR offsets, AXI encodings and FSM states shared by the stream-to-memory engine
package axi_stream_to_mem_pkg;
    localparam logic [4:0] CSR_CTRL   = 5'h00;
    localparam logic [4:0] CSR_STATUS = 5'h04;
    localparam logic [4:0] CSR_START  = 5'h08;
    localparam logic [4:0] CSR_END    = 5'h0C;
    localparam logic [4:0] CSR_COUNT  = 5'h10;
    localparam logic [4:0] CSR_CHUNK  = 5'h14;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] LOCK_NORMAL = 2'b00;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_AW   = 3'd2;
    localparam logic [2:0] ST_W    = 3'd3;
    localparam logic [2:0] ST_B    = 3'd4;
    function automatic logic [31:0] strb_merge(input logic [31:0] q, input logic [31:0] d, input logic [3:0] s);
        for (int i = 0; i < 4; i++)
            if (s[i]) q[i*8 +: 8] = d[i*8 +: 8];
        return q;
    endfunction
    function automatic logic [4:0] min5(input logic [4:0] a, input logic [4:0] b);
        return a < b ? a : b;
    endfunction
endpackage

// File: rtl/axi_stream_to_mem_if.sv
// axi_stream_to_mem_if: AXI3 write-only, AXI4-Stream and APB bundles used by the stream-to-memory engine
interface axi_wr_if #(parameter int CID = 2, parameter int ID = 4, parameter int AD = 32, parameter int DA = 64);
    logic [CID-1:0]  M_MID;
    logic [ID-1:0]   M_AWID;
    logic [AD-1:0]   M_AWADDR;
    logic [3:0]      M_AWLEN;
    logic [2:0]      M_AWSIZE;
    logic [1:0]      M_AWBURST;
    logic [1:0]      M_AWLOCK;
    logic            M_AWVALID;
    logic            M_AWREADY;
    logic [ID-1:0]   M_WID;
    logic [DA-1:0]   M_WDATA;
    logic [DA/8-1:0] M_WSTRB;
    logic            M_WLAST;
    logic            M_WVALID;
    logic            M_WREADY;
    logic [ID-1:0]   M_BID;
    logic [1:0]      M_BRESP;
    logic            M_BVALID;
    logic            M_BREADY;
    modport master(
        output M_MID, M_AWID, M_AWADDR, M_AWLEN, M_AWSIZE, M_AWBURST, M_AWLOCK, M_AWVALID,
               M_WID, M_WDATA, M_WSTRB, M_WLAST, M_WVALID, M_BREADY,
        input  M_AWREADY, M_WREADY, M_BID, M_BRESP, M_BVALID
    );
    modport slave(
        input  M_MID, M_AWID, M_AWADDR, M_AWLEN, M_AWSIZE, M_AWBURST, M_AWLOCK, M_AWVALID,
               M_WID, M_WDATA, M_WSTRB, M_WLAST, M_WVALID, M_BREADY,
        output M_AWREADY, M_WREADY, M_BID, M_BRESP, M_BVALID
    );
endinterface

interface axis_if #(parameter int DW = 64);
    logic            AXIS_TREADY;
    logic            AXIS_TVALID;
    logic [DW-1:0]   AXIS_TDATA;
    logic [DW/8-1:0] AXIS_TSTRB;
    logic            AXIS_TLAST;
    logic            AXIS_TSTART;
    modport master(output AXIS_TVALID, AXIS_TDATA, AXIS_TSTRB, AXIS_TLAST, AXIS_TSTART, input AXIS_TREADY);
    modport slave(input AXIS_TVALID, AXIS_TDATA, AXIS_TSTRB, AXIS_TLAST, AXIS_TSTART, output AXIS_TREADY);
endinterface

interface apb_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    modport master(output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, input PRDATA, PREADY, PSLVERR);
    modport slave(input PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/axi_stream_to_mem_fifo.sv
// axi_stream_to_mem_fifo: show-ahead synchronous FIFO with occupancy count and synchronous flush
module axi_stream_to_mem_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic [AW:0]  count
);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp, rp;
    assign count = wp - rp;
    assign full  = count[AW];
    assign dout  = mem[rp[AW-1:0]];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else if (clr) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + (AW+1)'(1);
            if (pop && count != '0) rp <= rp + (AW+1)'(1);
        end
    end
    always_ff @(posedge clk)
        if (push && !full) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/axi_stream_to_mem.sv
// axi_stream_to_mem: stores one AXI4-Stream packet to memory via AXI3 write bursts, APB-controlled
module axi_stream_to_mem
    import axi_stream_to_mem_pkg::*;
#(
    parameter int AXI_MST_ID      = 1,
    parameter int AXI_WIDTH_CID   = 2,
    parameter int AXI_WIDTH_ID    = 4,
    parameter int AXI_WIDTH_AD    = 32,
    parameter int AXI_WIDTH_DA    = 64,
    parameter int AXIS_WIDTH_DATA = 64,
    parameter int AXIS_WIDTH_DS   = AXIS_WIDTH_DATA/8,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic     ARESETn,
    input  logic     ACLK,
    axi_wr_if.master m_axi,
    axis_if.slave    s_axis,
    apb_if.slave     s_apb,
    output logic     IRQ
);
    localparam int BYTES = AXI_WIDTH_DA/8;
    localparam int SZ    = $clog2(BYTES);
    localparam int FW    = AXI_WIDTH_DA + BYTES + 1;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    logic [2:0]  state;
    logic        ie, done, err, irq, started, last_seen, burst_last;
    logic [31:0] start_q, end_q, byte_cnt, addr, rdata, rem, blen, next_addr;
    logic [4:0]  chunk_q, len, beat, chunk_b, rem_b, to4k_b, want;
    logic [12:0] to4k;
    logic [CW-1:0] fifo_cnt;
    logic [FW-1:0] fifo_dout;
    logic [AXI_WIDTH_DA-1:0] w_data;
    logic [BYTES-1:0] w_strb;
    logic        w_last, fifo_full, busy, wr, go, push, pop, have, wlast;
    logic [4:0]  ofs;
    logic        unused;
    assign busy = state != ST_IDLE;
    assign ofs  = s_apb.PADDR[4:0];
    assign wr   = s_apb.PSEL && s_apb.PENABLE && s_apb.PWRITE;
    assign go   = wr && ofs == CSR_CTRL && s_apb.PSTRB[0] && s_apb.PWDATA[0] && !busy;
    assign s_axis.AXIS_TREADY = busy && !fifo_full && !last_seen;
    // beats ahead of the packet's first beat are accepted and dropped
    assign push = s_axis.AXIS_TVALID && s_axis.AXIS_TREADY && (started || s_axis.AXIS_TSTART);
    assign pop  = state == ST_W && m_axi.M_WREADY;
    assign {w_data, w_strb, w_last} = fifo_dout;
    axi_stream_to_mem_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (ACLK),
        .rst_n (ARESETn),
        .clr   (go),
        .push  (push),
        .din   ({s_axis.AXIS_TDATA, s_axis.AXIS_TSTRB, s_axis.AXIS_TLAST}),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .count (fifo_cnt)
    );
    // burst length limited by CHUNK, remaining window to END and the next 4 KB page
    assign rem       = end_q > addr ? (end_q - addr) >> SZ : '0;
    assign to4k      = (13'h1000 - {1'b0, addr[11:0]}) >> SZ;
    assign rem_b     = rem > 32'd16 ? 5'd16 : rem[4:0];
    assign to4k_b    = to4k > 13'd16 ? 5'd16 : to4k[4:0];
    assign chunk_b   = (chunk_q == 5'd0 || chunk_q > 5'd16) ? 5'd16 : chunk_q;
    assign want      = min5(min5(chunk_b, rem_b), to4k_b);
    assign have      = 32'(fifo_cnt) >= 32'(want);
    assign blen      = 32'(len) << SZ;
    assign next_addr = addr + blen;
    assign wlast     = state == ST_W && beat == len - 5'd1;
    assign m_axi.M_MID     = AXI_WIDTH_CID'(AXI_MST_ID);
    assign m_axi.M_AWID    = '0;
    assign m_axi.M_WID     = '0;
    assign m_axi.M_AWADDR  = AXI_WIDTH_AD'(addr);
    assign m_axi.M_AWLEN   = 4'(len - 5'd1);
    assign m_axi.M_AWSIZE  = 3'(SZ);
    assign m_axi.M_AWBURST = BURST_INCR;
    assign m_axi.M_AWLOCK  = LOCK_NORMAL;
    assign m_axi.M_AWVALID = state == ST_AW;
    assign m_axi.M_WDATA   = w_data;
    assign m_axi.M_WSTRB   = w_strb;
    assign m_axi.M_WLAST   = wlast;
    assign m_axi.M_WVALID  = state == ST_W;
    assign m_axi.M_BREADY  = state == ST_B;
    assign s_apb.PREADY    = 1'b1;
    assign s_apb.PSLVERR   = 1'b0;
    assign IRQ = irq;
    assign unused = &{1'b0, m_axi.M_BID, s_apb.PPROT, s_apb.PADDR[31:5]};
    always_comb begin
        rdata = '0;
        case (ofs)
            CSR_CTRL:   rdata = {30'd0, ie, busy};
            CSR_STATUS: rdata = {29'd0, err, done, busy};
            CSR_START:  rdata = start_q;
            CSR_END:    rdata = end_q;
            CSR_COUNT:  rdata = byte_cnt;
            CSR_CHUNK:  rdata = {27'd0, chunk_q};
            default:    rdata = '0;
        endcase
    end
    assign s_apb.PRDATA = (s_apb.PSEL && s_apb.PENABLE && !s_apb.PWRITE) ? rdata : '0;
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state      <= ST_IDLE;
            ie         <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            irq        <= 1'b0;
            start_q    <= '0;
            end_q      <= '0;
            chunk_q    <= '0;
            byte_cnt   <= '0;
            addr       <= '0;
            len        <= '0;
            beat       <= '0;
            started    <= 1'b0;
            last_seen  <= 1'b0;
            burst_last <= 1'b0;
        end else begin
            irq <= ie & (done | err);
            if (wr) begin
                if (ofs == CSR_CTRL && s_apb.PSTRB[0]) ie <= s_apb.PWDATA[1];
                if (ofs == CSR_STATUS && s_apb.PSTRB[0]) begin
                    done <= done & ~s_apb.PWDATA[1];
                    err  <= err & ~s_apb.PWDATA[2];
                end
                if (ofs == CSR_START) start_q <= strb_merge(start_q, s_apb.PWDATA, s_apb.PSTRB) & ~32'(BYTES - 1);
                if (ofs == CSR_END) end_q <= strb_merge(end_q, s_apb.PWDATA, s_apb.PSTRB);
                if (ofs == CSR_CHUNK && s_apb.PSTRB[0]) chunk_q <= s_apb.PWDATA[4:0];
            end
            if (go) begin
                state     <= ST_WAIT;
                addr      <= start_q;
                byte_cnt  <= '0;
                started   <= 1'b0;
                last_seen <= 1'b0;
            end
            if (push) begin
                started   <= 1'b1;
                last_seen <= last_seen | s_axis.AXIS_TLAST;
            end
            // status set below overrides a same-cycle W1C
            case (state)
                ST_WAIT:
                    if (rem == '0) begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end else if (have || (last_seen && fifo_cnt != '0)) begin
                        len   <= have ? want : 5'(fifo_cnt);
                        state <= ST_AW;
                    end
                ST_AW:
                    if (m_axi.M_AWREADY) begin
                        beat       <= '0;
                        burst_last <= 1'b0;
                        state      <= ST_W;
                    end
                ST_W:
                    if (m_axi.M_WREADY) begin
                        beat       <= beat + 5'd1;
                        burst_last <= burst_last | w_last;
                        if (wlast) state <= ST_B;
                    end
                ST_B:
                    if (m_axi.M_BVALID) begin
                        addr     <= next_addr;
                        byte_cnt <= byte_cnt + blen;
                        if (m_axi.M_BRESP != RESP_OKAY) err <= 1'b1;
                        if (m_axi.M_BRESP != RESP_OKAY || burst_last || next_addr >= end_q) begin
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end else state <= ST_WAIT;
                    end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_stream_to_mem.sv
// tb_axi_stream_to_mem: directed checks of CSRs, burst splitting, END and 4 KB limits, and error response
module tb_axi_stream_to_mem;
    import axi_stream_to_mem_pkg::*;
    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    logic IRQ;
    always #5 ACLK = ~ACLK;
    axi_wr_if m ();
    axis_if   s ();
    apb_if    p ();
    axi_stream_to_mem dut (.ARESETn(ARESETn), .ACLK(ACLK), .m_axi(m), .s_axis(s), .s_apb(p), .IRQ(IRQ));
    int tests = 0;
    int fails = 0;
    logic [31:0] aw_addr [$];
    logic [3:0]  aw_len [$];
    logic [63:0] mem [logic [31:0]];
    logic        stall = 1'b0;
    logic [1:0]  resp = 2'b00;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // memory-side slave: handshakes decided at negedge take effect on the following posedge
    initial begin : slave
        logic [31:0] wa;
        logic [63:0] w;
        int nb;
        bit b_pend, b_fire;
        wa = '0; nb = 0; b_pend = 0; b_fire = 0;
        m.M_AWREADY = 0; m.M_WREADY = 0; m.M_BVALID = 0; m.M_BRESP = 0; m.M_BID = '0;
        forever begin
            @(negedge ACLK);
            if (b_fire) begin m.M_BVALID = 0; b_fire = 0; end
            if (b_pend) begin m.M_BVALID = 1; m.M_BRESP = resp; b_pend = 0; end
            m.M_AWREADY = stall ? 1'($urandom_range(1)) : 1'b1;
            m.M_WREADY  = stall ? 1'($urandom_range(1)) : 1'b1;
            if (m.M_AWVALID && m.M_AWREADY) begin
                aw_addr.push_back(m.M_AWADDR);
                aw_len.push_back(m.M_AWLEN);
                wa = m.M_AWADDR;
                nb = 0;
            end
            if (m.M_WVALID && m.M_WREADY) begin
                w = mem.exists(wa) ? mem[wa] : '0;
                for (int i = 0; i < 8; i++)
                    if (m.M_WSTRB[i]) w[i*8 +: 8] = m.M_WDATA[i*8 +: 8];
                mem[wa] = w;
                wa += 8;
                nb++;
                if (m.M_WLAST) begin
                    chk("wlast_pos", 64'(nb), 64'(aw_len[$]) + 64'd1);
                    b_pend = 1;
                end
            end
            if (m.M_BVALID && m.M_BREADY) b_fire = 1;
        end
    end
    task automatic apb_wr(input logic [31:0] a, input logic [31:0] d);
        @(posedge ACLK); #1;
        p.PSEL = 1; p.PENABLE = 0; p.PWRITE = 1; p.PADDR = a; p.PWDATA = d; p.PSTRB = 4'hf;
        @(posedge ACLK); #1;
        p.PENABLE = 1;
        @(posedge ACLK); #1;
        p.PSEL = 0; p.PENABLE = 0; p.PWRITE = 0;
    endtask
    task automatic apb_rd(input logic [31:0] a, output logic [31:0] d);
        @(posedge ACLK); #1;
        p.PSEL = 1; p.PENABLE = 0; p.PWRITE = 0; p.PADDR = a;
        @(posedge ACLK); #1;
        p.PENABLE = 1;
        @(negedge ACLK);
        d = p.PRDATA;
        @(posedge ACLK); #1;
        p.PSEL = 0; p.PENABLE = 0;
    endtask
    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        apb_rd(a, d);
        chk(tag, 64'(d), 64'(exp));
    endtask
    task automatic send(input logic [63:0] d, input logic st, input logic ls);
        bit ok;
        ok = 0;
        s.AXIS_TVALID = 1; s.AXIS_TDATA = d; s.AXIS_TSTRB = '1; s.AXIS_TSTART = st; s.AXIS_TLAST = ls;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge ACLK);
            ok = s.AXIS_TREADY;
        end
        @(posedge ACLK); #1;
        s.AXIS_TVALID = 0;
        if (!ok) chk("tready_timeout", 64'd0, 64'd1);
    endtask
    task automatic pkt(input logic [63:0] base, input int n, input logic has_last);
        for (int i = 0; i < n; i++) send(base + 64'(i), i == 0, has_last && i == n - 1);
    endtask
    task automatic wait_done(input string tag);
        logic [31:0] d;
        int n;
        d = '0; n = 0;
        while (!d[1] && n < 300) begin
            apb_rd(32'(CSR_STATUS), d);
            n++;
        end
        chk({tag, "_done"}, 64'(d[1]), 64'd1);
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int n;
        p.PSEL = 0; p.PENABLE = 0; p.PWRITE = 0; p.PADDR = '0; p.PWDATA = '0; p.PSTRB = '0; p.PPROT = '0;
        s.AXIS_TVALID = 0; s.AXIS_TDATA = '0; s.AXIS_TSTRB = '0; s.AXIS_TLAST = 0; s.AXIS_TSTART = 0;
        repeat (3) @(posedge ACLK);
        #1 ARESETn = 1;
        chk("rst_tready", 64'(s.AXIS_TREADY), 64'd0);
        chk("rst_irq", 64'(IRQ), 64'd0);
        chk("rst_awvalid", 64'(m.M_AWVALID), 64'd0);
        chk("rst_wvalid", 64'(m.M_WVALID), 64'd0);
        chk("rst_pready", 64'(p.PREADY), 64'd1);
        chk("rst_pslverr", 64'(p.PSLVERR), 64'd0);
        rd_chk("rst_ctrl", 32'h00, 32'h0);
        rd_chk("rst_status", 32'h04, 32'h0);
        rd_chk("rst_start", 32'h08, 32'h0);
        rd_chk("rst_end", 32'h0C, 32'h0);
        rd_chk("rst_count", 32'h10, 32'h0);
        rd_chk("rst_chunk", 32'h14, 32'h0);
        // 16-beat packet split into two 8-beat bursts, preceded by a beat to discard
        apb_wr(32'h08, 32'h0);
        apb_wr(32'h0C, 32'h400);
        apb_wr(32'h14, 32'd8);
        apb_wr(32'h00, 32'h3);
        rd_chk("t2_busy", 32'h04, 32'h1);
        rd_chk("t2_ctrl_busy", 32'h00, 32'h3);
        send(64'hdead, 1'b0, 1'b0);
        pkt(64'h1000, 16, 1'b1);
        wait_done("t2");
        chk("t2_naw", 64'(aw_addr.size()), 64'd2);
        chk("t2_aw0", 64'(aw_addr[0]), 64'h0);
        chk("t2_len0", 64'(aw_len[0]), 64'd7);
        chk("t2_aw1", 64'(aw_addr[1]), 64'h40);
        chk("t2_len1", 64'(aw_len[1]), 64'd7);
        rd_chk("t2_count", 32'h10, 32'h80);
        rd_chk("t2_status", 32'h04, 32'h2);
        rd_chk("t2_ctrl", 32'h00, 32'h2);
        chk("t2_irq", 64'(IRQ), 64'd1);
        chk("t2_mem0", mem[32'h0], 64'h1000);
        chk("t2_mem78", mem[32'h78], 64'h100f);
        apb_wr(32'h04, 32'h2);
        repeat (2) @(posedge ACLK);
        #1 chk("t2_irq_clr", 64'(IRQ), 64'd0);
        rd_chk("t2_status_clr", 32'h04, 32'h0);
        // short packet flushed by TLAST below the chunk size
        aw_addr.delete(); aw_len.delete();
        apb_wr(32'h00, 32'h3);
        pkt(64'hA0, 5, 1'b1);
        wait_done("t3");
        chk("t3_naw", 64'(aw_addr.size()), 64'd1);
        chk("t3_len", 64'(aw_len[0]), 64'd4);
        rd_chk("t3_count", 32'h10, 32'h28);
        chk("t3_mem0", mem[32'h0], 64'hA0);
        chk("t3_mem20", mem[32'h20], 64'hA4);
        chk("t3_mem28", mem[32'h28], 64'h1005);
        apb_wr(32'h04, 32'h6);
        // END reached before TLAST: stream stalls afterwards
        aw_addr.delete(); aw_len.delete();
        apb_wr(32'h08, 32'h100);
        apb_wr(32'h0C, 32'h120);
        apb_wr(32'h00, 32'h3);
        pkt(64'hB0, 4, 1'b0);
        wait_done("t4");
        chk("t4_naw", 64'(aw_addr.size()), 64'd1);
        chk("t4_aw0", 64'(aw_addr[0]), 64'h100);
        chk("t4_len", 64'(aw_len[0]), 64'd3);
        rd_chk("t4_count", 32'h10, 32'h20);
        rd_chk("t4_status", 32'h04, 32'h2);
        chk("t4_mem118", mem[32'h118], 64'hB3);
        s.AXIS_TVALID = 1; s.AXIS_TSTART = 0; s.AXIS_TLAST = 0; s.AXIS_TDATA = 64'hB4;
        n = 0;
        repeat (8) begin
            @(negedge ACLK);
            n += int'(s.AXIS_TREADY);
        end
        s.AXIS_TVALID = 0;
        chk("t4_stalled", 64'(n), 64'd0);
        apb_wr(32'h04, 32'h6);
        // 4 KB boundary split, CHUNK=0 meaning 16, random ready stalls
        aw_addr.delete(); aw_len.delete();
        stall = 1;
        apb_wr(32'h08, 32'hFE0);
        apb_wr(32'h0C, 32'h2000);
        apb_wr(32'h14, 32'd0);
        apb_wr(32'h00, 32'h3);
        pkt(64'hC0, 8, 1'b1);
        wait_done("t5");
        chk("t5_naw", 64'(aw_addr.size()), 64'd2);
        chk("t5_aw0", 64'(aw_addr[0]), 64'hFE0);
        chk("t5_len0", 64'(aw_len[0]), 64'd3);
        chk("t5_aw1", 64'(aw_addr[1]), 64'h1000);
        chk("t5_len1", 64'(aw_len[1]), 64'd3);
        rd_chk("t5_count", 32'h10, 32'h40);
        chk("t5_memfe0", mem[32'hFE0], 64'hC0);
        chk("t5_memff8", mem[32'hFF8], 64'hC3);
        chk("t5_mem1018", mem[32'h1018], 64'hC7);
        apb_wr(32'h04, 32'h6);
        // SLVERR response stops the engine
        aw_addr.delete(); aw_len.delete();
        resp = 2'b10;
        apb_wr(32'h08, 32'h200);
        apb_wr(32'h0C, 32'h400);
        apb_wr(32'h14, 32'd4);
        apb_wr(32'h00, 32'h3);
        pkt(64'hD0, 4, 1'b0);
        wait_done("t6");
        repeat (20) @(posedge ACLK);
        #1;
        rd_chk("t6_status", 32'h04, 32'h6);
        chk("t6_irq", 64'(IRQ), 64'd1);
        chk("t6_naw", 64'(aw_addr.size()), 64'd1);
        rd_chk("t6_count", 32'h10, 32'h20);
        chk("t6_mem218", mem[32'h218], 64'hD3);
        stall = 0;
        resp = 2'b00;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
